// File: rtl/mult_accum_sequencer.sv
// Dot-product sequencer: streams N operand reads into a registered multiplier and accumulates products.
// Latency: start accepted end of cycle 0 -> reads cycles 1..N -> out_valid cycle N+3 (N=0: cycle 1).
// Backpressure: result held in DONE until out_ready; optional issue throttle via MULT_SEQ_STALL_EN.
module mult_accum_sequencer #(
    parameter int W_a   = 32,
    parameter int W_b   = 32,
    parameter int LEN_W = 8
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         start,
    input  logic [LEN_W-1:0]             len,
`ifdef MULT_SEQ_STALL_EN
    input  logic                         stall,
`endif
    output logic                         busy,
    output logic                         rd_en,
    output logic [LEN_W-1:0]             rd_addr,
    input  logic [W_a-1:0]               rd_data_a,
    input  logic [W_b-1:0]               rd_data_b,
    output logic [W_a-1:0]               mult_a,
    output logic [W_b-1:0]               mult_b,
    input  logic [W_a+W_b-1:0]           mult_p,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W_a+W_b+LEN_W-1:0]     out_data
);
    localparam int ACC_W = W_a + W_b + LEN_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  addr_q;
    logic [ACC_W-1:0]  acc;
    logic              v1, v2;
    logic              issue;
    logic              last_issue;
    logic              accept;
    logic              hold;

`ifdef MULT_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign accept     = (state == IDLE) && start;
    assign last_issue = issue && (addr_q == len_q - LEN_W'(1));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue = !hold;
                if (issue && (addr_q == len_q - LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // v1 empty means the product now in v2 is the last one and lands this edge
                if (!v1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            len_q  <= '0;
            addr_q <= '0;
            acc    <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
        end else begin
            state <= state_nxt;
            v1    <= issue;
            v2    <= v1;
            if (accept) begin
                len_q  <= len;
                addr_q <= '0;
                acc    <= '0;
            end else begin
                if (last_issue) begin
                    addr_q <= '0;
                end else if (issue) begin
                    addr_q <= addr_q + LEN_W'(1);
                end
                if (v2) begin
                    acc <= acc + ACC_W'(mult_p);
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign rd_en    = issue;
    assign rd_addr  = addr_q;
    assign mult_a   = rd_data_a;
    assign mult_b   = rd_data_b;
    assign out_data = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_mult_accum_sequencer.sv
// Bench for mult_accum_sequencer: vector table plus hand sequences for backpressure, reset and stall.
module tb_mult_accum_sequencer;

    logic        Clock;
    logic        Reset;
    logic        start;
    logic [7:0]  len;
    logic        stall;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [63:0] mult_p;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    mult_accum_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (start),
        .len       (len),
`ifdef MULT_SEQ_STALL_EN
        .stall     (stall),
`endif
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous operand memories and a one-cycle registered multiplier
    always @(posedge Clock) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
        mult_p <= 64'(mult_a) * 64'(mult_b);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0: begin mem_a[i] = 32'(i + 1); mem_b[i] = 32'(i + 5); end
                1: begin mem_a[i] = 32'hFFFF_FFFF; mem_b[i] = 32'hFFFF_FFFF; end
                2: begin mem_a[i] = 32'(i + 3); mem_b[i] = 32'(i + 5); end
                default: begin mem_a[i] = 32'(i + 7); mem_b[i] = 32'd9; end
            endcase
        end
    endtask

    // One operation with out_ready high; cycle 0 is the cycle start is presented
    task automatic run_op(input int n, input int slo, input int shi,
                          output int vcyc, output logic [71:0] data,
                          output int rdcnt, output bit addr_ok, output bit idle_ok);
        vcyc = -1; data = '0; rdcnt = 0; addr_ok = 1'b1; idle_ok = 1'b0;
        @(posedge Clock); #1;
        start = 1'b1; len = n[7:0]; stall = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                @(posedge Clock); #1;
                start = 1'b0;
                stall = (c >= slo) && (c <= shi);
            end
            @(negedge Clock);
            if (rd_en) begin
                if (rd_addr != rdcnt[7:0]) addr_ok = 1'b0;
                rdcnt++;
            end
            if (out_valid) begin
                vcyc = c;
                data = out_data;
                break;
            end
        end
        stall = 1'b0;
        if (vcyc < 0) return;
        @(posedge Clock); #1;
        @(negedge Clock);
        idle_ok = !busy && !out_valid && !rd_en;
    endtask

    typedef struct {
        int          len;
        int          pat;
        logic [71:0] exp_data;
        int          exp_vcyc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          vcyc;
        logic [71:0] data;
        int          rdcnt;
        bit          addr_ok;
        bit          idle_ok;
        bit          got;
        bit          stable;

        vecs[0] = '{len: 4,   pat: 0, exp_data: 72'd70,                 exp_vcyc: 7};
        vecs[1] = '{len: 0,   pat: 0, exp_data: 72'd0,                  exp_vcyc: 1};
        vecs[2] = '{len: 255, pat: 1, exp_data: 72'hFE_FFFFFE02_000000FF, exp_vcyc: 258};
        vecs[3] = '{len: 2,   pat: 2, exp_data: 72'd39,                 exp_vcyc: 5};
        vecs[4] = '{len: 1,   pat: 3, exp_data: 72'd63,                 exp_vcyc: 4};
        vecs[5] = '{len: 3,   pat: 3, exp_data: 72'd216,                exp_vcyc: 6};

        Reset = 1'b1; start = 1'b0; len = '0; stall = 1'b0; out_ready = 1'b1;
        fill(0);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("reset_busy",      busy,      1'b0);
        check("reset_rd_en",     rd_en,     1'b0);
        check("reset_rd_addr",   rd_addr,   8'd0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data",  out_data,  72'd0);

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].pat);
            run_op(vecs[i].len, 1000, -1, vcyc, data, rdcnt, addr_ok, idle_ok);
            check($sformatf("vec%0d_data", i),     data,    vecs[i].exp_data);
            check($sformatf("vec%0d_vcyc", i),     vcyc,    vecs[i].exp_vcyc);
            check($sformatf("vec%0d_rd_count", i), rdcnt,   vecs[i].len);
            check($sformatf("vec%0d_rd_addr", i),  addr_ok, 1'b1);
            check($sformatf("vec%0d_idle", i),     idle_ok, 1'b1);
        end

        // Held result under backpressure with start pulsed while busy
        fill(3);
        @(posedge Clock); #1;
        out_ready = 1'b0; start = 1'b1; len = 8'd1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clock); #1;
            start = 1'b0;
            @(negedge Clock);
            if (out_valid) begin got = 1'b1; break; end
        end
        check("bp_valid_seen", got, 1'b1);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clock); #1;
            start = 1'b1; len = 8'd3;
            @(negedge Clock);
            if (!out_valid || out_data !== 72'd63 || rd_en) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        @(posedge Clock); #1;
        out_ready = 1'b1; start = 1'b1; len = 8'd3;
        @(negedge Clock);
        check("bp_handshake_valid", out_valid, 1'b1);
        @(posedge Clock); #1;
        start = 1'b1; len = 8'd2;
        @(negedge Clock);
        check("bp_idle_after", {busy, rd_en, out_valid}, 3'b000);
        @(posedge Clock); #1;
        start = 1'b0;
        @(negedge Clock);
        check("b2b_run_issue", {rd_en, rd_addr}, {1'b1, 8'd0});
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin got = 1'b1; data = out_data; break; end
            @(posedge Clock); #1;
            @(negedge Clock);
        end
        check("b2b_valid_seen", got, 1'b1);
        check("b2b_data", data, 72'd135);
        @(posedge Clock); #1;

        // Reset during a run discards in-flight work
        fill(0);
        @(posedge Clock); #1;
        start = 1'b1; len = 8'd4;
        @(posedge Clock); #1;
        start = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_c3_running", rd_en, 1'b1);
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_c4_outputs", {rd_en, busy, out_valid}, 3'b000);
        check("rst_c4_data", out_data, 72'd0);
        fill(2);
        run_op(2, 1000, -1, vcyc, data, rdcnt, addr_ok, idle_ok);
        check("rst_then_data", data, 72'd39);
        check("rst_then_vcyc", vcyc, 5);
        check("rst_then_rd_count", rdcnt, 2);

`ifdef MULT_SEQ_STALL_EN
        fill(0);
        run_op(4, 2, 4, vcyc, data, rdcnt, addr_ok, idle_ok);
        check("stall_data",     data,    72'd70);
        check("stall_vcyc",     vcyc,    10);
        check("stall_rd_count", rdcnt,   4);
        check("stall_rd_addr",  addr_ok, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
